mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter.sv | 138 +++++++++++++
 tb/tb_mult_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one multiplier between two requesters.
//
// Ports
//   clock, reset              single clock, asynchronous active-high reset
//   req0Valid/req0In1/req0In2 requester 0 operation, held until req0Ready
//   req0Ready, resp0Valid     requester 0 accept strobe and result pulse
//   req1*                     same set for requester 1
//   respOut, respErr          shared registered product and timeout flag,
//                             qualified by resp0Valid/resp1Valid
//   mulIn1, mulIn2, mulStart  operands and start pulse to the multiplier
//   mulDone, mulOut           multiplier completion and product
//   busy                      high whenever not in IDLE
//   timeoutErr                sticky, set by any timeout until reset
module mult_arbiter #(
  parameter int WIDTH    = 10,
  parameter int OUTWIDTH = 2 * WIDTH,
  parameter int TIMEOUT  = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req0Valid,
  input  logic [WIDTH-1:0]    req0In1,
  input  logic [WIDTH-1:0]    req0In2,
  output logic                req0Ready,
  output logic                resp0Valid,
  input  logic                req1Valid,
  input  logic [WIDTH-1:0]    req1In1,
  input  logic [WIDTH-1:0]    req1In2,
  output logic                req1Ready,
  output logic                resp1Valid,
  output logic [OUTWIDTH-1:0] respOut,
  output logic                respErr,
  output logic [WIDTH-1:0]    mulIn1,
  output logic [WIDTH-1:0]    mulIn2,
  output logic                mulStart,
  input  logic                mulDone,
  input  logic [OUTWIDTH-1:0] mulOut,
  output logic                busy,
  output logic                timeoutErr
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KICK = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t        state, state_n;
  logic          last_grant;   // requester granted most recently
  logic          owner;        // requester owning the in-flight operation
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          grant0, grant1;
  logic          timed_out;

  assign cnt_inc = cnt + CW'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    timed_out  = 1'b0;
    unique case (state)
      IDLE: begin
        // On a tie the requester that was not granted last wins.
        if (req0Valid && (!req1Valid || last_grant)) grant0 = 1'b1;
        else if (req1Valid)                           grant1 = 1'b1;
        if (grant0 || grant1) state_n = KICK;
      end
      KICK: state_n = WAIT;
      WAIT: begin
        // mulDone takes priority over a timeout landing in the same cycle.
        timed_out = !mulDone && (cnt_inc == TO_LIMIT);
        if (mulDone || timed_out) state_n = RESP;
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign req0Ready  = grant0;
  assign req1Ready  = grant1;
  assign mulStart   = (state == KICK);
  assign busy       = (state != IDLE);
  assign resp0Valid = (state == RESP) && !owner;
  assign resp1Valid = (state == RESP) && owner;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      mulIn1     <= '0;
      mulIn2     <= '0;
      cnt        <= '0;
      respOut    <= '0;
      respErr    <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      if (grant0) begin
        mulIn1     <= req0In1;
        mulIn2     <= req0In2;
        owner      <= 1'b0;
        last_grant <= 1'b0;
      end else if (grant1) begin
        mulIn1     <= req1In1;
        mulIn2     <= req1In2;
        owner      <= 1'b1;
        last_grant <= 1'b1;
      end

      if (state == KICK) cnt <= '0;

      if (state == WAIT) begin
        if (mulDone) begin
          respOut <= mulOut;
          respErr <= 1'b0;
        end else begin
          cnt <= cnt_inc;
          if (timed_out) begin
            respOut    <= '0;
            respErr    <= 1'b1;
            timeoutErr <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: vector table plus hand sequences for mult_arbiter,
// with a behavioural multiplier and a response scoreboard.
module tb_mult_arbiter;

  localparam int W  = 10;
  localparam int OW = 20;
  localparam int TO = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0Valid, req1Valid;
  logic [W-1:0]  req0In1, req0In2, req1In1, req1In2;
  logic          req0Ready, req1Ready, resp0Valid, resp1Valid;
  logic [OW-1:0] respOut;
  logic          respErr;
  logic [W-1:0]  mulIn1, mulIn2;
  logic          mulStart;
  logic          mulDone = 1'b0;
  logic [OW-1:0] mulOut;
  logic          busy, timeoutErr;

  mult_arbiter #(.WIDTH(W), .OUTWIDTH(OW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req0Valid(req0Valid), .req0In1(req0In1), .req0In2(req0In2),
    .req0Ready(req0Ready), .resp0Valid(resp0Valid),
    .req1Valid(req1Valid), .req1In1(req1In1), .req1In2(req1In2),
    .req1Ready(req1Ready), .resp1Valid(resp1Valid),
    .respOut(respOut), .respErr(respErr),
    .mulIn1(mulIn1), .mulIn2(mulIn2), .mulStart(mulStart),
    .mulDone(mulDone), .mulOut(mulOut),
    .busy(busy), .timeoutErr(timeoutErr)
  );

  always #5 clock = ~clock;

  // Product only while done; all-ones otherwise exposes a stray capture.
  logic [OW-1:0] prod;
  assign prod   = OW'(mulIn1) * OW'(mulIn2);
  assign mulOut = mulDone ? prod : '1;

  typedef struct {
    logic          owner;
    logic [W-1:0]  a, b;
    logic [OW-1:0] out;
    logic          err;
    int            elat;
  } exp_t;

  typedef struct {
    logic          owner;
    logic [W-1:0]  a, b;
    int            mode;   // 0 pulse after lat, 1 done held high, 2 never
    int            lat;
    logic [OW-1:0] out;
    logic          err;
    int            elat;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   mul_mode = 0;
  int   mul_lat  = 4;
  int   mcnt     = 0;
  bit   pulse;
  bit   start_due  = 0;
  bit   exp_sticky = 0;
  bit   acc_n [2];
  exp_t sbq[$];
  int   acc_cyc[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Multiplier model and output monitor, both away from the active edge.
  always @(negedge clock) begin
    exp_t e;
    int   a0;
    cyc++;
    pulse = 1'b0;
    if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) pulse = 1'b1;
    end
    if (mulStart && mul_mode == 0) mcnt = mul_lat;
    mulDone = (mul_mode == 1) ? 1'b1 : pulse;

    if (!reset) begin
      if (start_due || mulStart) chk("mulStart", 64'(mulStart), 64'(start_due));
      start_due = 1'b0;

      if (req0Ready || req1Ready) begin
        chk("ready_onehot", 64'(req0Ready & req1Ready), 64'd0);
        chk("ready_busy", 64'(busy), 64'd0);
        if (req0Ready) begin chk("ready0_valid", 64'(req0Valid), 64'd1); acc_n[0] = 1'b1; end
        if (req1Ready) begin chk("ready1_valid", 64'(req1Valid), 64'd1); acc_n[1] = 1'b1; end
        acc_cyc.push_back(cyc);
        start_due = 1'b1;
      end

      if (resp0Valid || resp1Valid) begin
        chk("resp_onehot", 64'(resp0Valid & resp1Valid), 64'd0);
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: got resp0=%0b resp1=%0b want none", resp0Valid, resp1Valid);
        end else begin
          e  = sbq.pop_front();
          a0 = (acc_cyc.size() > 0) ? acc_cyc.pop_front() : -1000;
          chk("resp_owner", 64'(resp1Valid), 64'(e.owner));
          chk("respOut", 64'(respOut), 64'(e.out));
          chk("respErr", 64'(respErr), 64'(e.err));
          chk("latency", 64'(cyc - a0), 64'(e.elat + 2));
          chk("mulIn1", 64'(mulIn1), 64'(e.a));
          chk("mulIn2", 64'(mulIn2), 64'(e.b));
          chk("resp_busy", 64'(busy), 64'd1);
          if (e.err) exp_sticky = 1'b1;
          chk("timeoutErr", 64'(timeoutErr), 64'(exp_sticky));
        end
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready0", 64'(req0Ready), 64'd0);
    chk("rst_ready1", 64'(req1Ready), 64'd0);
    chk("rst_resp0", 64'(resp0Valid), 64'd0);
    chk("rst_resp1", 64'(resp1Valid), 64'd0);
    chk("rst_mulStart", 64'(mulStart), 64'd0);
    chk("rst_respOut", 64'(respOut), 64'd0);
    chk("rst_respErr", 64'(respErr), 64'd0);
    chk("rst_timeoutErr", 64'(timeoutErr), 64'd0);
    chk("rst_mulIn1", 64'(mulIn1), 64'd0);
    chk("rst_mulIn2", 64'(mulIn2), 64'd0);
  endtask

  task automatic apply_reset();
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals();
    sbq.delete();
    acc_cyc.delete();
    start_due  = 1'b0;
    exp_sticky = 1'b0;
    acc_n[0]   = 1'b0;
    acc_n[1]   = 1'b0;
    @(posedge clock);
    #2;
    reset = 1'b0;
  endtask

  task automatic wait_acc(input logic who);
    int k;
    for (k = 0; k < 50; k++) begin
      @(posedge clock);
      #1;
      if (acc_n[who]) break;
    end
    if (!acc_n[who]) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: requester %0d got no ready within 50 cycles", who);
    end
    acc_n[who] = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clock);
      #1;
      if (sbq.size() == 0 && !busy) break;
    end
    if (sbq.size() != 0 || busy) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: pending=%0d busy=%0b want 0 and 0", sbq.size(), busy);
    end
  endtask

  task automatic drive(input logic who, input logic [W-1:0] a, input logic [W-1:0] b, input logic on);
    if (!who) begin req0Valid = on; req0In1 = a; req0In2 = b; end
    else      begin req1Valid = on; req1In1 = a; req1In2 = b; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs [8];
    exp_t e;
    int   n0, n1, k;

    vecs[0] = '{1'b0, 10'd3,    10'd5,    0, 4, 20'd15,      1'b0, 4};
    vecs[1] = '{1'b1, 10'd1023, 10'd1023, 0, 2, 20'd1046529, 1'b0, 2};
    vecs[2] = '{1'b0, 10'd0,    10'd777,  1, 0, 20'd0,       1'b0, 1};
    vecs[3] = '{1'b1, 10'd12,   10'd34,   1, 0, 20'd408,     1'b0, 1};
    vecs[4] = '{1'b0, 10'd21,   10'd22,   0, 8, 20'd462,     1'b0, 8};
    vecs[5] = '{1'b0, 10'd100,  10'd200,  2, 0, 20'd0,       1'b1, 8};
    vecs[6] = '{1'b1, 10'd5,    10'd6,    0, 9, 20'd0,       1'b1, 8};
    vecs[7] = '{1'b1, 10'd7,    10'd9,    0, 3, 20'd63,      1'b0, 3};

    reset = 1'b1;
    req0Valid = 1'b0; req0In1 = '0; req0In2 = '0;
    req1Valid = 1'b0; req1In1 = '0; req1In2 = '0;
    acc_n[0] = 1'b0;
    acc_n[1] = 1'b0;
    #3;
    check_reset_vals();
    @(posedge clock);
    #2;
    reset = 1'b0;

    foreach (vecs[i]) begin
      mul_mode = vecs[i].mode;
      mul_lat  = vecs[i].lat;
      @(posedge clock);
      #1;
      drive(vecs[i].owner, vecs[i].a, vecs[i].b, 1'b1);
      sbq.push_back('{vecs[i].owner, vecs[i].a, vecs[i].b, vecs[i].out, vecs[i].err, vecs[i].elat});
      wait_acc(vecs[i].owner);
      drive(vecs[i].owner, '0, '0, 1'b0);
      wait_idle();
    end
    mul_mode = 0;

    // Reset while waiting on the multiplier: the late done must be ignored.
    mul_lat = 6;
    @(posedge clock);
    #1;
    drive(1'b0, 10'd11, 10'd13, 1'b1);
    sbq.push_back('{1'b0, 10'd11, 10'd13, 20'd143, 1'b0, 6});
    wait_acc(1'b0);
    drive(1'b0, '0, '0, 1'b0);
    repeat (3) @(posedge clock);
    apply_reset();
    repeat (12) @(negedge clock);
    #1;
    chk("post_reset_busy", 64'(busy), 64'd0);

    // Both requesters valid from reset: grants alternate starting with 0.
    mul_lat = 2;
    for (int i = 0; i < 4; i++) begin
      sbq.push_back('{1'b0, W'(i + 1), W'(10 + i), OW'((i + 1) * (10 + i)), 1'b0, 2});
      sbq.push_back('{1'b1, W'(50 + i), W'(3 + i), OW'((50 + i) * (3 + i)), 1'b0, 2});
    end
    @(posedge clock);
    #1;
    drive(1'b0, 10'd1, 10'd10, 1'b1);
    drive(1'b1, 10'd50, 10'd3, 1'b1);
    n0 = 0;
    n1 = 0;
    for (k = 0; k < 400 && (n0 < 4 || n1 < 4); k++) begin
      @(posedge clock);
      #1;
      if (acc_n[0]) begin
        acc_n[0] = 1'b0;
        n0++;
        drive(1'b0, W'(n0 + 1), W'(10 + n0), n0 < 4);
      end
      if (acc_n[1]) begin
        acc_n[1] = 1'b0;
        n1++;
        drive(1'b1, W'(50 + n1), W'(3 + n1), n1 < 4);
      end
    end
    if (n0 < 4 || n1 < 4) begin
      total++;
      bad++;
      $display("FAIL alternate_timeout: accepts got %0d/%0d want 4/4", n0, n1);
    end
    drive(1'b0, '0, '0, 1'b0);
    drive(1'b1, '0, '0, 1'b0);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
